// File: rtl/seq_decimal_display.sv
`default_nettype none
// ============================================================================
//  Module      : seq_decimal_display
//  Description : Sequential binary-to-decimal seven-segment display driver.
//                Iterative shift-and-add-3 (double dabble), one bit per clock,
//                with start/busy/done handshake, leading-zero blanking and
//                overflow flag. Display outputs hold between updates.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_decimal_display #(
    parameter int         WIDTH     = 16,
    parameter int         DIGITS    = 5,
    parameter logic [6:0] SEG_BLANK = 7'b1111111
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      val,
    input  logic                  lz_blank,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf,
    output logic [7*DIGITS-1:0]   seg7
);

    localparam int         c_CNT_W = $clog2(WIDTH + 1);
    localparam int         c_BCD_W = 4 * DIGITS;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_CONV  = 2'd1;
    localparam logic [1:0] c_LATCH = 2'd2;

    // Active-low segment encoder, bit order {g,f,e,d,c,b,a}.
    // Non-decimal nibbles cannot occur in a valid BCD register; show them dark.
    function automatic logic [6:0] seven_segment(input logic [3:0] digit);
        logic [6:0] pat;
        case (digit)
            4'd0:    pat = 7'b1000000;
            4'd1:    pat = 7'b1111001;
            4'd2:    pat = 7'b0100100;
            4'd3:    pat = 7'b0110000;
            4'd4:    pat = 7'b0011001;
            4'd5:    pat = 7'b0010010;
            4'd6:    pat = 7'b0000010;
            4'd7:    pat = 7'b1111000;
            4'd8:    pat = 7'b0000000;
            4'd9:    pat = 7'b0010000;
            default: pat = 7'b1111111;
        endcase
        return pat;
    endfunction

    logic [1:0]          r_state;
    logic [WIDTH-1:0]    r_shift;
    logic [c_BCD_W-1:0]  r_bcd;
    logic                r_ovf_sticky;
    logic                r_lz;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_done;
    logic                r_ovf;
    logic [7*DIGITS-1:0] r_seg7;

    logic [c_BCD_W-1:0]  w_bcd_adj;
    logic [7*DIGITS-1:0] w_seg;
    logic                w_leading;

    assign busy = (r_state != c_IDLE);
    assign done = r_done;
    assign ovf  = r_ovf;
    assign seg7 = r_seg7;

    // Add-3 correction: every BCD nibble of 5 or more is bumped before the shift.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_bcd[4*k +: 4] >= 4'd5) begin
                w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
            end
        end
    end

    // Decode digits, blanking zeros above the highest non-zero digit (never digit 0).
    always_comb begin
        w_seg     = '0;
        w_leading = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            if (r_bcd[4*k +: 4] != 4'd0) begin
                w_leading = 1'b0;
            end
            if (r_lz && w_leading && (k != 0)) begin
                w_seg[7*k +: 7] = SEG_BLANK;
            end else begin
                w_seg[7*k +: 7] = seven_segment(r_bcd[4*k +: 4]);
            end
        end
    end

    // Control FSM, conversion datapath and registered display outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_shift      <= '0;
            r_bcd        <= '0;
            r_ovf_sticky <= 1'b0;
            r_lz         <= 1'b0;
            r_cnt        <= '0;
            r_done       <= 1'b0;
            r_ovf        <= 1'b0;
            r_seg7       <= {DIGITS{SEG_BLANK}};
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_shift      <= val;
                        r_bcd        <= '0;
                        r_ovf_sticky <= 1'b0;
                        r_lz         <= lz_blank;
                        r_cnt        <= c_CNT_W'(WIDTH);
                        r_state      <= c_CONV;
                    end
                end
                c_CONV: begin
                    // The bit leaving the top nibble is a carry past 10^DIGITS.
                    r_bcd        <= {w_bcd_adj[c_BCD_W-2:0], r_shift[WIDTH-1]};
                    r_shift      <= {r_shift[WIDTH-2:0], 1'b0};
                    r_ovf_sticky <= r_ovf_sticky | w_bcd_adj[c_BCD_W-1];
                    r_cnt        <= r_cnt - c_CNT_W'(1);
                    if (r_cnt == c_CNT_W'(1)) begin
                        r_state <= c_LATCH;
                    end
                end
                c_LATCH: begin
                    r_seg7  <= w_seg;
                    r_ovf   <= r_ovf_sticky;
                    r_done  <= 1'b1;
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_decimal_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_decimal_display
//  Description : Scoreboard bench for seq_decimal_display. Two instances
//                (5 and 4 digits) share one stimulus stream; a decimal
//                reference model fills an expectation queue, a monitor
//                compares outputs every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_decimal_display;

    localparam logic [6:0] c_BL  = 7'b1111111;
    localparam int         c_LAT = 17;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        lz_blank = 1'b0;
    logic [15:0] val = '0;

    logic        busy5, done5, ovf5;
    logic [34:0] seg5;
    logic        busy4, done4, ovf4;
    logic [27:0] seg4;

    seq_decimal_display #(.WIDTH(16), .DIGITS(5), .SEG_BLANK(c_BL)) u_dut5 (
        .clk(clk), .rst(rst), .start(start), .val(val), .lz_blank(lz_blank),
        .busy(busy5), .done(done5), .ovf(ovf5), .seg7(seg5)
    );

    seq_decimal_display #(.WIDTH(16), .DIGITS(4), .SEG_BLANK(c_BL)) u_dut4 (
        .clk(clk), .rst(rst), .start(start), .val(val), .lz_blank(lz_blank),
        .busy(busy4), .done(done4), .ovf(ovf4), .seg7(seg4)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          t_acc;
        logic [34:0] s5;
        logic [27:0] s4;
        logic        o4;
    } exp_t;

    exp_t        q[$];
    bit          have_acc = 1'b0;
    int          m_tacc = 0;
    logic [34:0] cur5 = {5{c_BL}};
    logic [27:0] cur4 = {4{c_BL}};
    logic        cur_o4 = 1'b0;
    bit          exp_done;
    bit          exp_busy;
    exp_t        pe;
    int          bnd[10] = '{0, 9, 10, 99, 100, 999, 1000, 9999, 10000, 65535};

    function automatic logic [6:0] enc(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    // Decimal view of the value: low d digits of v, blanked above the top non-zero digit.
    function automatic logic [34:0] ref_disp(input int v, input int d, input bit lz);
        logic [34:0] r;
        int p, m, pk;
        r = '0;
        p = 1;
        for (int k = 0; k < d; k++) p = p * 10;
        m = v % p;
        pk = 1;
        for (int k = 0; k < d; k++) begin
            if (lz && (k > 0) && (m < pk)) r[7*k +: 7] = c_BL;
            else                           r[7*k +: 7] = enc((m / pk) % 10);
            pk = pk * 10;
        end
        return r;
    endfunction

    // The DUT is busy during cycles t_acc .. t_acc+16 after an accepted start.
    function automatic bit m_busy();
        return have_acc && (cyc <= m_tacc + c_LAT - 1);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: sample just after each rising edge, compare against the scoreboard.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            q.delete();
            cur5     = {5{c_BL}};
            cur4     = {4{c_BL}};
            cur_o4   = 1'b0;
            exp_done = 1'b0;
        end else begin
            exp_done = (q.size() > 0) && (cyc == q[0].t_acc + c_LAT);
        end
        exp_busy = m_busy();
        check("done", {63'd0, done5}, {63'd0, exp_done});
        check("done_d4", {63'd0, done4}, {63'd0, exp_done});
        if (exp_done) begin
            pe     = q.pop_front();
            cur5   = pe.s5;
            cur4   = pe.s4;
            cur_o4 = pe.o4;
        end
        check("busy", {63'd0, busy5}, {63'd0, exp_busy});
        check("busy_d4", {63'd0, busy4}, {63'd0, exp_busy});
        check("seg7", {29'd0, seg5}, {29'd0, cur5});
        check("seg7_d4", {36'd0, seg4}, {36'd0, cur4});
        check("ovf", {63'd0, ovf5}, 64'd0);
        check("ovf_d4", {63'd0, ovf4}, {63'd0, cur_o4});
    end

    task automatic issue(input int v, input bit lz);
        exp_t        e;
        logic [34:0] t;
        val      = v[15:0];
        lz_blank = lz;
        start    = 1'b1;
        if (!rst && !m_busy()) begin
            have_acc = 1'b1;
            m_tacc   = cyc + 1;
            e.t_acc  = m_tacc;
            e.s5     = ref_disp(v, 5, lz);
            t        = ref_disp(v, 4, lz);
            e.s4     = t[27:0];
            e.o4     = (v >= 10000);
            q.push_back(e);
        end
        @(negedge clk);
        start    = 1'b0;
        val      = 16'($urandom);
        lz_blank = 1'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            val      = 16'($urandom);
            lz_blank = 1'($urandom);
        end
    endtask

    // Advance until the model says the DUT is idle; optionally poke ignored starts.
    task automatic wait_idle(input bit junk);
        while (m_busy()) begin
            start    = junk && ($urandom_range(0, 7) == 0);
            val      = 16'($urandom);
            lz_blank = 1'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst      = 1'b1;
        have_acc = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int v;
        bit lz;
        @(negedge clk);
        do_reset(3);
        idle(2);

        issue(12345, 1'b0); wait_idle(1'b0);
        issue(0, 1'b1);     wait_idle(1'b0);
        issue(700, 1'b1);   wait_idle(1'b0);
        issue(700, 1'b0);   wait_idle(1'b0);
        issue(65535, 1'b0); wait_idle(1'b0);
        issue(9999, 1'b0);  wait_idle(1'b0);

        // Start while busy is ignored; start on the done cycle is accepted.
        issue(111, 1'b0);
        idle(3);
        issue(222, 1'b0);
        wait_idle(1'b0);
        issue(333, 1'b0);
        wait_idle(1'b0);

        // Abort mid-conversion with reset, then convert again.
        issue(12345, 1'b0); wait_idle(1'b0);
        issue(54321, 1'b0);
        idle(6);
        do_reset(1);
        idle(3);
        issue(54321, 1'b0); wait_idle(1'b0);

        // Reset and start together: reset wins.
        rst      = 1'b1;
        have_acc = 1'b0;
        issue(4321, 1'b1);
        rst = 1'b0;
        idle(2);
        issue(4321, 1'b1); wait_idle(1'b0);

        // Randomised traffic with boundary values and ignored starts while busy.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) v = bnd[$urandom_range(0, 9)];
            else                           v = int'($urandom_range(0, 65535));
            lz = 1'($urandom);
            issue(v, lz);
            wait_idle(1'b1);
            idle($urandom_range(0, 2));
        end

        wait_idle(1'b0);
        idle(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
